matmul_16x16_job_ctrl: RTL and testbench
========================================

Name: matmul_16x16_job_ctrl

Overview:
Job sequencer for the 16x16 matmul top, which is built from 8x8 systolic tiles and has A/B/C BRAMs.
- Accepts a job-start pulse, then streams A and B words from a valid/ready input into the A/B BRAMs through the shared addr_pi/data_pi port.
- Pulses the datapath reset, holds start_mat_mul_0 until done_mat_mul, then sweeps C addresses and returns results on a backpressured valid/ready output.
- Sits between the host/DMA stream and the matmul top; it is the sole driver of all matmul-top control inputs.

Parameters:
DWIDTH, 16, element width
BB, 8, elements per BRAM word (port data width is BB*DWIDTH = 128)
AWIDTH, 7, BRAM address width
A_WORDS, 16, words written with we_a (range 1..2^AWIDTH)
B_WORDS, 16, words written with we_b (range 1..2^AWIDTH)
C_WORDS, 16, words read back (range 1..2^AWIDTH)
ADDR_LEAD, 2, cycles that addr_pi precedes data_pi/we_* at the top (the address is re-registered twice inside the top)
RD_LAT, 6, cycles from addr_pi driven (enable_reading_from_mem high) to a valid data_from_out_mat
DP_RST_CYCLES, 2, length of the datapath reset pulse
TIMEOUT, 4096, maximum COMPUTE cycles before error
FIFO_DEPTH, 8, output buffer depth; must be >= RD_LAT+1

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
job_start  in  1  one-cycle pulse; accepted only in IDLE
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid&in_ready
in_data  in  BB*DWIDTH  A words, then B words
out_valid  out  1  result word valid
out_ready  in  1  consumer ready
out_data  out  BB*DWIDTH  C word, address order 0..C_WORDS-1
busy  out  1  high in every state except IDLE
job_done  out  1  one-cycle pulse when the last C word is accepted
err_timeout  out  1  sticky; cleared only by resetn or by the next accepted job_start
reset_0  out  1  active-high synchronous datapath reset to the matmul top
start_mat_mul_0  out  1  to matmul top
done_mat_mul  in  1  from matmul top
enable_writing_to_mem  out  1  to top
enable_reading_from_mem  out  1  to top
addr_pi  out  AWIDTH  to top
data_pi  out  BB*DWIDTH  to top
we_a, we_b, we_c  out  1  to top; we_c is tied 0

Behaviour:
- Async reset values:
  - State IDLE.
  - All outputs 0, except reset_0=1 (datapath held in reset while resetn is low).
  - FIFO empty; all counters 0.
- FSM states: IDLE, DP_RST, LOAD_A, LOAD_B, LOAD_FLUSH, COMPUTE, DRAIN, FINISH, ERR.
- IDLE:
  - reset_0=0 after the first clk following resetn deassertion.
  - job_start -> DP_RST; clears err_timeout.
- DP_RST: reset_0=1 for DP_RST_CYCLES cycles -> LOAD_A.
- LOAD_A / LOAD_B:
  - enable_writing_to_mem=1; in_ready=1.
  - Each handshake on cycle t:
    - addr_pi=word index at t.
    - data_pi=in_data and we_a (or we_b)=1 at t+ADDR_LEAD, via an internal ADDR_LEAD-stage delay line.
  - Input stalls insert bubbles; we_* is never high for a non-handshaked slot.
  - After A_WORDS handshakes -> LOAD_B with the index reset to 0.
  - After B_WORDS handshakes -> LOAD_FLUSH.
- LOAD_FLUSH:
  - in_ready=0; enable_writing_to_mem held for ADDR_LEAD cycles so delayed writes complete -> COMPUTE.
- COMPUTE:
  - start_mat_mul_0=1 from the first COMPUTE cycle.
  - done_mat_mul sampled high -> start_mat_mul_0=0 on the next cycle -> DRAIN.
  - The cycle counter reaching TIMEOUT without done -> ERR: err_timeout=1, start_mat_mul_0=0, reset_0 pulsed for DP_RST_CYCLES, then IDLE.
- DRAIN:
  - enable_reading_from_mem=1.
  - Issues addr_pi=0..C_WORDS-1, one per cycle, only while (fifo_count + inflight) < FIFO_DEPTH. This credit rule means the FIFO never overflows.
  - A shift register of depth RD_LAT tags returning words; tagged data_from_out_mat is pushed into the FIFO.
  - out_valid = FIFO non-empty; out_data = FIFO head; first-word fall-through.
  - The FIFO supports simultaneous push and pop in one cycle, including when full with pop (push allowed).
- FINISH:
  - Entered after all C_WORDS are issued and the FIFO has drained.
  - job_done pulses as the last word is accepted -> IDLE.
- job_start outside IDLE is ignored; no queueing.
- in_valid outside the LOAD states is ignored; in_ready=0.
- resetn low mid-job: immediate return to reset values, partial results discarded.

Test Plan:
1. Reset with resetn=0 for 3 cycles -> all outputs 0, reset_0=1, busy=0. After release: reset_0=0 and busy=0 at the next clk.
2. Full job, A=16 and B=16 words with in_valid always high, model done_mat_mul 40 cycles after start, out_ready=1:
   - reset_0 high 2 cycles.
   - we_a high for exactly 16 cycles, with addr_pi=k two cycles before data word k.
   - start_mat_mul_0 drops the cycle after done.
   - 16 outputs in order 0..15.
   - job_done exactly once.
3. in_valid toggling 1,0,1,0 during the loads -> we_a/we_b gaps align with the stalls; the total write count is 32; addresses are contiguous 0..15.
4. Drain with out_ready low for 20 cycles from the start of DRAIN -> issued addresses stop at FIFO_DEPTH - in-flight. No word is lost or duplicated, and all 16 words are delivered in order after out_ready rises.
5. done_mat_mul never asserted, TIMEOUT=64 -> err_timeout=1 after 64 COMPUTE cycles, a 2-cycle reset_0 pulse, return to IDLE with busy=0. The next job_start clears err_timeout.
6. resetn asserted during DRAIN after the 5th output -> outputs return to reset values immediately. A following job completes with 16 correct words.

Source files
------------

// File: rtl/matmul_16x16_job_ctrl.sv
// Job sequencer for the 16x16 matmul top: loads A/B BRAMs from an input stream,
// runs the multiply, then drains C through a credit-managed output FIFO.
module matmul_16x16_job_ctrl #(
  parameter int DWIDTH        = 16,
  parameter int BB            = 8,
  parameter int AWIDTH        = 7,
  parameter int A_WORDS       = 16,
  parameter int B_WORDS       = 16,
  parameter int C_WORDS       = 16,
  parameter int ADDR_LEAD     = 2,
  parameter int RD_LAT        = 6,
  parameter int DP_RST_CYCLES = 2,
  parameter int TIMEOUT       = 4096,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   job_start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BB*DWIDTH-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BB*DWIDTH-1:0]   out_data,
  output logic                   busy,
  output logic                   job_done,
  output logic                   err_timeout,
  output logic                   reset_0,
  output logic                   start_mat_mul_0,
  input  logic                   done_mat_mul,
  input  logic [BB*DWIDTH-1:0]   data_from_out_mat,
  output logic                   enable_writing_to_mem,
  output logic                   enable_reading_from_mem,
  output logic [AWIDTH-1:0]      addr_pi,
  output logic [BB*DWIDTH-1:0]   data_pi,
  output logic                   we_a,
  output logic                   we_b,
  output logic                   we_c
);
  localparam int DW = BB*DWIDTH;
  localparam int CW = AWIDTH + 1;
  localparam int TW = ($clog2(TIMEOUT+1) > 8) ? $clog2(TIMEOUT+1) : 8;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW = $clog2(FIFO_DEPTH+1);

  typedef enum logic [3:0] {
    IDLE, DP_RST, LOAD_A, LOAD_B, LOAD_FLUSH, COMPUTE, DRAIN, FINISH, ERR
  } state_t;

  state_t state, state_n;
  logic por;
  logic [TW-1:0] cnt;
  logic [CW-1:0] idx, iss, acc;
  logic [ADDR_LEAD:1] wl_vld, wl_b;
  logic [ADDR_LEAD:1][DW-1:0] wl_data;
  logic [RD_LAT:1] vld_pipe;
  logic [DW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [FW-1:0] fcnt;
  logic hs, issue, push, do_push, pop, last_pop, err_q;

  assign in_ready    = (state == LOAD_A) || (state == LOAD_B);
  assign hs          = in_valid & in_ready;
  assign out_valid   = (fcnt != '0);
  assign out_data    = out_valid ? fifo_mem[rp] : '0;
  assign pop         = out_valid & out_ready;
  assign push        = vld_pipe[RD_LAT];
  assign do_push     = push && ((fcnt != FW'(FIFO_DEPTH)) || pop);
  assign last_pop    = pop && (acc == CW'(C_WORDS-1));
  // Credit: words already buffered plus words still in the read pipe never exceed the FIFO.
  assign issue       = (state == DRAIN) && (iss < CW'(C_WORDS)) &&
                       ((int'(fcnt) + $countones(vld_pipe)) < FIFO_DEPTH);
  assign busy        = (state != IDLE);
  assign reset_0     = por || (state == DP_RST) || (state == ERR);
  assign err_timeout = err_q;
  assign data_pi     = wl_data[ADDR_LEAD];
  assign we_a        = wl_vld[ADDR_LEAD] & ~wl_b[ADDR_LEAD];
  assign we_b        = wl_vld[ADDR_LEAD] &  wl_b[ADDR_LEAD];
  assign we_c        = 1'b0;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else         state <= state_n;

  always_comb begin
    state_n                 = state;
    enable_writing_to_mem   = 1'b0;
    enable_reading_from_mem = 1'b0;
    start_mat_mul_0         = 1'b0;
    addr_pi                 = '0;
    job_done                = 1'b0;
    unique case (state)
      IDLE:       if (job_start) state_n = DP_RST;
      DP_RST:     if (cnt == TW'(DP_RST_CYCLES-1)) state_n = LOAD_A;
      LOAD_A: begin
        enable_writing_to_mem = 1'b1;
        addr_pi = idx[AWIDTH-1:0];
        if (hs && idx == CW'(A_WORDS-1)) state_n = LOAD_B;
      end
      LOAD_B: begin
        enable_writing_to_mem = 1'b1;
        addr_pi = idx[AWIDTH-1:0];
        if (hs && idx == CW'(B_WORDS-1)) state_n = LOAD_FLUSH;
      end
      LOAD_FLUSH: begin
        enable_writing_to_mem = 1'b1;
        if (cnt == TW'(ADDR_LEAD-1)) state_n = COMPUTE;
      end
      COMPUTE: begin
        start_mat_mul_0 = 1'b1;
        if (done_mat_mul)                  state_n = DRAIN;
        else if (cnt == TW'(TIMEOUT-1))    state_n = ERR;
      end
      DRAIN: begin
        enable_reading_from_mem = 1'b1;
        addr_pi  = iss[AWIDTH-1:0];
        job_done = last_pop;
        if (last_pop) state_n = FINISH;
      end
      FINISH:     state_n = IDLE;
      ERR:        if (cnt == TW'(DP_RST_CYCLES-1)) state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) por <= 1'b1;
    else         por <= 1'b0;

  // Per-state dwell counter, shared by reset pulses, write flush and compute timeout.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn)                 cnt <= '0;
    else if (state_n != state)   cnt <= '0;
    else if (state != IDLE)      cnt <= cnt + 1'b1;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn)                                   err_q <= 1'b0;
    else if (state == IDLE && job_start)           err_q <= 1'b0;
    else if (state == COMPUTE && state_n == ERR)   err_q <= 1'b1;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      idx <= '0;
      iss <= '0;
      acc <= '0;
    end else if (state == IDLE) begin
      idx <= '0;
      iss <= '0;
      acc <= '0;
    end else begin
      if (hs)
        idx <= ((state == LOAD_A && idx == CW'(A_WORDS-1)) ||
                (state == LOAD_B && idx == CW'(B_WORDS-1))) ? '0 : idx + 1'b1;
      if (issue) iss <= iss + 1'b1;
      if (pop)   acc <= acc + 1'b1;
    end

  // Write data trails its address by ADDR_LEAD cycles to match the top's address registers.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wl_vld   <= '0;
      wl_b     <= '0;
      wl_data  <= '0;
      vld_pipe <= '0;
    end else begin
      wl_vld[1]   <= hs;
      wl_b[1]     <= (state == LOAD_B);
      wl_data[1]  <= hs ? in_data : '0;
      vld_pipe[1] <= issue;
      for (int k = 2; k <= ADDR_LEAD; k++) begin
        wl_vld[k]  <= wl_vld[k-1];
        wl_b[k]    <= wl_b[k-1];
        wl_data[k] <= wl_data[k-1];
      end
      for (int k = 2; k <= RD_LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
    end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wp   <= '0;
      rp   <= '0;
      fcnt <= '0;
    end else begin
      if (do_push) wp <= (wp == PW'(FIFO_DEPTH-1)) ? '0 : wp + 1'b1;
      if (pop)     rp <= (rp == PW'(FIFO_DEPTH-1)) ? '0 : rp + 1'b1;
      unique case ({do_push, pop})
        2'b10:   fcnt <= fcnt + 1'b1;
        2'b01:   fcnt <= fcnt - 1'b1;
        default: fcnt <= fcnt;
      endcase
    end

  always_ff @(posedge clk)
    if (do_push) fifo_mem[wp] <= data_from_out_mat;

endmodule

// File: tb/tb_matmul_16x16_job_ctrl.sv
// Randomized bench for matmul_16x16_job_ctrl with a behavioural model of the
// matmul top (BRAM write capture, done timing, fixed-latency C reads).
module tb_matmul_16x16_job_ctrl;
  localparam int DW = 128, AW = 7, NA = 16, NB = 16, NC = 16;
  localparam int RDL = 6, FD = 8, TO = 64, DPR = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn = 1'b0, job_start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic done_mat_mul = 1'b0;
  logic in_ready, out_valid, busy, job_done, err_timeout, reset_0, start_mat_mul_0;
  logic en_w, en_r, we_a, we_b, we_c;
  logic [DW-1:0] in_data = '0, out_data, data_pi, data_from_out_mat;
  logic [AW-1:0] addr_pi;
  logic [10:0] ctl;
  assign ctl = {busy, in_ready, out_valid, job_done, err_timeout, start_mat_mul_0,
                en_w, en_r, we_a, we_b, we_c};

  matmul_16x16_job_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .job_start(job_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .job_done(job_done), .err_timeout(err_timeout),
    .reset_0(reset_0), .start_mat_mul_0(start_mat_mul_0), .done_mat_mul(done_mat_mul),
    .data_from_out_mat(data_from_out_mat),
    .enable_writing_to_mem(en_w), .enable_reading_from_mem(en_r),
    .addr_pi(addr_pi), .data_pi(data_pi), .we_a(we_a), .we_b(we_b), .we_c(we_c));

  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Job data and scoreboard counters
  logic [DW-1:0] words [NA+NB];
  logic [DW-1:0] cmem [NC];
  int in_ptr = 0, wa = 0, wb = 0, ocnt = 0, jd = 0, r0 = 0, sc = 0;
  int done_dly = 0, vmode = 0, or_hold = 0, or_rand = 0;
  logic tog = 1'b0, hs = 1'b0, hs1 = 1'b0, hs2 = 1'b0, hold_last = 1'b0, done_prev = 1'b0;
  logic [AW-1:0] a1 = '0, a2 = '0;

  // Matmul top model: done after done_dly start cycles, C reads return RDL cycles later
  logic [RDL-1:0] hv = '0;
  logic [AW-1:0] ha [RDL];
  int scnt = 0;
  assign data_from_out_mat = hv[RDL-1] ? cmem[ha[RDL-1]] : {4{32'hdeadbeef}};

  always @(posedge clk) begin
    hv[0] <= en_r;
    ha[0] <= addr_pi;
    for (int k = 1; k < RDL; k++) begin
      hv[k] <= hv[k-1];
      ha[k] <= ha[k-1];
    end
    scnt <= start_mat_mul_0 ? scnt + 1 : 0;
    done_mat_mul <= start_mat_mul_0 && (done_dly > 0) && (scnt == done_dly - 1);
  end

  // Drive stream inputs at negedge, then observe the settled cycle 1 time unit later
  always @(negedge clk) begin
    tog = ~tog;
    case (vmode)
      0:       in_valid = 1'b1;
      1:       in_valid = tog;
      default: in_valid = 1'($urandom_range(0, 1));
    endcase
    in_data = (in_ptr < NA+NB) ? words[in_ptr] : {$urandom(), $urandom(), $urandom(), $urandom()};
    hold_last = 1'b0;
    if (en_r && or_hold > 0) begin
      out_ready = 1'b0;
      or_hold--;
      hold_last = (or_hold == 0);
    end else begin
      out_ready = (or_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    #1;
    if (!resetn) begin
      hs1 = 1'b0; hs2 = 1'b0; a1 = '0; a2 = '0; done_prev = 1'b0;
    end else begin
      hs = in_valid & in_ready;
      if (hs) in_ptr++;
      chk("we_align", DW'(we_a | we_b), DW'(hs2));
      if (we_a) begin
        chk("wa_addr", DW'(a2), DW'(wa));
        chk("wa_data", data_pi, words[wa % (NA+NB)]);
        wa++;
      end
      if (we_b) begin
        chk("wb_addr", DW'(a2), DW'(wb));
        chk("wb_data", data_pi, words[(NA+wb) % (NA+NB)]);
        wb++;
      end
      if (hold_last) chk("credit_stop", DW'(addr_pi), DW'(FD));
      if (done_prev) chk("start_drop", DW'(start_mat_mul_0), '0);
      if (out_valid && out_ready) begin
        chk("out_data", out_data, cmem[ocnt % NC]);
        chk("jd_on_pop", DW'(job_done), DW'(ocnt == NC-1));
        ocnt++;
      end
      if (job_done) jd++;
      if (reset_0) r0++;
      if (start_mat_mul_0) sc++;
      done_prev = done_mat_mul;
      hs2 = hs1; hs1 = hs;
      a2 = a1; a1 = addr_pi;
    end
  end

  task automatic start_job(input int vm, input int hold, input int dly, input int rnd);
    @(negedge clk);
    for (int i = 0; i < NA+NB; i++) words[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int i = 0; i < NC; i++)    cmem[i]  = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_ptr = 0; wa = 0; wb = 0; ocnt = 0; jd = 0; r0 = 0; sc = 0;
    vmode = vm; or_hold = hold; done_dly = dly; or_rand = rnd;
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    #2;
    chk("err_clr", DW'(err_timeout), '0);
    chk("busy_start", DW'(busy), DW'(1'b1));
  endtask

  task automatic run_job(input int vm, input int hold, input int dly, input int rnd, input bit ok);
    start_job(vm, hold, dly, rnd);
    for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
    chk("job_end_busy", DW'(busy), '0);
    chk("n_we_a", DW'(wa), DW'(NA));
    chk("n_we_b", DW'(wb), DW'(NB));
    if (ok) begin
      chk("n_out", DW'(ocnt), DW'(NC));
      chk("n_job_done", DW'(jd), DW'(1));
      chk("n_reset_0", DW'(r0), DW'(DPR));
      chk("n_start", DW'(sc), DW'(dly + 1));
      chk("err_flag", DW'(err_timeout), '0);
    end else begin
      chk("n_out_to", DW'(ocnt), '0);
      chk("n_job_done_to", DW'(jd), '0);
      chk("n_reset_0_to", DW'(r0), DW'(2*DPR));
      chk("n_start_to", DW'(sc), DW'(TO));
      chk("err_flag_to", DW'(err_timeout), DW'(1'b1));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"},   DW'(ctl), '0);
    chk({tag, "_addr"},  DW'(addr_pi), '0);
    chk({tag, "_dpi"},   data_pi, '0);
    chk({tag, "_dout"},  out_data, '0);
    chk({tag, "_rst0"},  DW'(reset_0), DW'(1'b1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset behaviour
    resetn = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      chk_reset_vals("rst");
    end
    @(negedge clk);
    resetn = 1'b1;
    #1 chk("rst0_pre_clk", DW'(reset_0), DW'(1'b1));
    @(negedge clk); #1;
    chk("rst0_after", DW'(reset_0), '0);
    chk("busy_after", DW'(busy), '0);

    run_job(0, 0, 40, 0, 1'b1);            // streaming loads, free output
    run_job(1, 0, 40, 0, 1'b1);            // alternating input stalls
    run_job(0, 20, 40, 0, 1'b1);           // output backpressure at start of drain
    run_job(0, 0, 0, 0, 1'b0);             // done never arrives -> timeout
    run_job(0, 0, 30, 0, 1'b1);            // err_timeout cleared by this start
    repeat (3) run_job(2, 0, int'($urandom_range(1, 60)), 1, 1'b1);

    // Reset in the middle of the drain
    start_job(0, 0, 40, 0);
    for (int i = 0; i < 2000 && ocnt < 5; i++) @(negedge clk);
    chk("pre_rst_outs", DW'(ocnt), DW'(5));
    resetn = 1'b0;
    #1 chk_reset_vals("mid");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_job(2, 0, 25, 1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
